axi_hp_mem_responder: RTL and testbench
=======================================

Name: axi_hp_mem_responder

Overview:
- AXI4 (4-bit length) memory responder: the slave end of the DMA write and read masters exported by the ad9361 PL wrapper.
- Stands in for the PS HP port in PL-only simulation and loopback builds.
- ADC DMA write bursts land in an internal 64-bit word memory; DAC DMA read bursts are served from the same memory.
- Write and read channels run independently.

Parameters:
- MEM_ADDR_WIDTH, 10, log2 of memory depth in 64-bit words (default 1024 words = 8 KiB).
- BASE_ADDR, 32'h00000000, byte address of word 0; window = BASE_ADDR .. BASE_ADDR + 8*2^MEM_ADDR_WIDTH - 1.

Ports:
- axi_aclk  input  1  clock for all logic.
- axi_aresetn  input  1  asynchronous active-low reset.
- s_axi_awaddr/awlen/awsize/awburst  input  32/4/3/2  write address, beats-1, size, burst type.
- s_axi_awprot/awcache  input  3/4  accepted, ignored.
- s_axi_awvalid  input  1 / s_axi_awready  output  1  AW handshake.
- s_axi_wdata/wstrb/wlast  input  64/8/1  write data, byte strobes, last flag.
- s_axi_wvalid  input  1 / s_axi_wready  output  1  W handshake.
- s_axi_bresp  output  2 / s_axi_bvalid  output  1 / s_axi_bready  input  1  write response.
- s_axi_araddr/arlen/arsize/arburst  input  32/4/3/2  read address fields.
- s_axi_arprot/arcache  input  3/4  accepted, ignored.
- s_axi_arvalid  input  1 / s_axi_arready  output  1  AR handshake.
- s_axi_rdata/rresp/rlast  output  64/2/1  read data, response, last flag.
- s_axi_rvalid  output  1 / s_axi_rready  input  1  R handshake.
- err_count  output  16  saturating count of non-OKAY responses issued.

Behaviour:
- Reset values: awready=1, arready=1, wready=0, bvalid=0, bresp=0, rvalid=0, rlast=0, rresp=0, rdata=0, err_count=0.
- Reset mid-burst aborts the burst. Memory contents are not cleared.
- Word index = (addr - BASE_ADDR) >> 3, taken modulo depth.
- Burst address step:
  - INCR (2'b01): +1 word per beat.
  - FIXED (2'b00): no step.
  - WRAP (2'b10) or reserved (2'b11): the error check below applies.
- Error check, evaluated once at address acceptance:
  - DECERR (2'b11) if start < BASE_ADDR, or if start + 8*len lies past the window end (INCR only).
  - Otherwise SLVERR (2'b10) if size != 3 or the burst type is WRAP/reserved.
  - Otherwise OKAY.
  - An errored write burst stores nothing. An errored read burst returns rdata=0 with that rresp on every beat.
- Write FSM:
  - W_IDLE: awready=1. On AW handshake, latch addr, len and error; go to W_DATA.
  - W_DATA: wready=1. Each W handshake writes the enabled bytes (wstrb bit i -> byte i) when error-free, advances the address, and increments the beat count.
  - W_DATA exits to W_RESP on beat len+1 regardless of wlast.
  - wlast mismatch (wlast high before the final beat, or low on it) forces bresp=SLVERR unless DECERR is already set. Earlier beats are still written.
  - W_RESP: bvalid=1 with bresp held stable until bready; then W_IDLE.
  - AW is not accepted again before the B handshake completes. awready is registered and drops the cycle after acceptance.
- Read FSM:
  - R_IDLE: arready=1. On AR handshake go to R_FETCH.
  - R_FETCH: one cycle; synchronous memory read. Then R_DATA.
  - R_DATA: rvalid=1. rdata/rresp/rlast are held stable until rready. rlast=1 on beat len+1.
  - On the R handshake: after the final beat go to R_IDLE; otherwise go to R_FETCH with the address advanced.
  - Latency: AR handshake -> first rvalid = 2 cycles. Peak throughput = 1 beat per 2 cycles.
- Simultaneous write and read of the same word in the same cycle: the read returns the old data (read-first memory).
- err_count increments by 1 on each B handshake with bresp != 0, and on each R handshake with rlast=1 and rresp != 0. It saturates at 16'hFFFF.

Optional Feature:
- Macro: AXI_HP_MEM_BACKPRESSURE_EN.
- Defined: an internal 8-bit LFSR (seed 8'hA5, polynomial x^8+x^6+x^5+x^4+1, advancing every cycle) gates wready and the R_FETCH -> R_DATA advance.
  - When LFSR bit0 = 0, wready is forced 0 and R_FETCH stalls.
  - All other rules are unchanged.
- Not defined: no LFSR logic; timing exactly as above.

Test Plan:
- INCR write: awaddr=BASE+0x40, awlen=3, wdata 0x11..44 replicated, wstrb=8'hFF, wlast on beat 4 -> bresp=OKAY one cycle after beat 4; words 8..11 hold the data; err_count=0.
- Partial strobe: write 0xFFFF_FFFF_FFFF_FFFF with wstrb=8'h0F over word 0x0 -> read awlen=0 returns 0x0000_0000_FFFF_FFFF (memory pre-zeroed by a prior write); rlast=1; rvalid 2 cycles after AR.
- Read INCR awlen=3 from BASE+0x40 with rready toggling 1,0,1,0 -> beats 0x11..,0x22..,0x33..,0x44.. in order; data held while rready=0; rlast only on beat 4.
- Out-of-range write: awaddr=BASE+8*1020, awlen=7 -> DECERR; memory unchanged; err_count=1. Read with arsize=2 -> every beat rresp=SLVERR, rdata=0; err_count=2.
- wlast low on the final beat of awlen=1 -> bresp=SLVERR; both beats written; FSM returns to W_IDLE.
- axi_aresetn pulsed low mid read burst -> rvalid=0 and arready=1 immediately. A new read afterwards returns the stored data correctly.

Source files
------------

// File: rtl/axi_hp_mem_responder_if.sv
// AXI4 (4-bit length) write/read channel bundle between a DMA master and the HP memory responder.
interface axi_hp_mem_responder_if;
    logic [31:0] awaddr;
    logic [3:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [2:0]  awprot;
    logic [3:0]  awcache;
    logic        awvalid;
    logic        awready;
    logic [63:0] wdata;
    logic [7:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic [3:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [2:0]  arprot;
    logic [3:0]  arcache;
    logic        arvalid;
    logic        arready;
    logic [63:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;

    modport slave (
        input  awaddr, awlen, awsize, awburst, awprot, awcache, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready,
        input  araddr, arlen, arsize, arburst, arprot, arcache, arvalid,
        output arready,
        output rdata, rresp, rlast, rvalid,
        input  rready
    );

    modport master (
        output awaddr, awlen, awsize, awburst, awprot, awcache, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready,
        output araddr, arlen, arsize, arburst, arprot, arcache, arvalid,
        input  arready,
        input  rdata, rresp, rlast, rvalid,
        output rready
    );
endinterface

// File: rtl/axi_hp_mem_responder.sv
// AXI4 HP-port memory responder: 64-bit word memory serving independent write and read bursts.
// Optional AXI_HP_MEM_BACKPRESSURE_EN adds LFSR-driven stalls on wready and the read fetch.
module axi_hp_mem_responder #(
    parameter int          MEM_ADDR_WIDTH = 10,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000
) (
    input  logic                  axi_aclk,
    input  logic                  axi_aresetn,
    axi_hp_mem_responder_if.slave s_axi,
    output logic [15:0]           err_count
);
    localparam int          DEPTH       = 1 << MEM_ADDR_WIDTH;
    localparam logic [33:0] WIN_END     = {2'b00, BASE_ADDR} + (34'd8 << MEM_ADDR_WIDTH) - 34'd1;
    localparam logic [1:0]  RESP_OKAY   = 2'b00;
    localparam logic [1:0]  RESP_SLVERR = 2'b10;
    localparam logic [1:0]  RESP_DECERR = 2'b11;
    localparam logic [1:0]  BURST_INCR  = 2'b01;

    function automatic logic [1:0] addr_check(input logic [31:0] addr, input logic [3:0] len,
                                              input logic [2:0] size, input logic [1:0] burst);
        logic [33:0] last_byte;
        last_byte = {2'b00, addr} + {27'd0, len, 3'b000};
        if (addr < BASE_ADDR) return RESP_DECERR;
        if (burst == BURST_INCR && last_byte > WIN_END) return RESP_DECERR;
        if (size != 3'd3 || burst[1]) return RESP_SLVERR;
        return RESP_OKAY;
    endfunction

    function automatic logic [MEM_ADDR_WIDTH-1:0] word_index(input logic [31:0] addr);
        return MEM_ADDR_WIDTH'((addr - BASE_ADDR) >> 3);
    endfunction

    function automatic logic [15:0] sat_add(input logic [15:0] cnt, input logic [1:0] inc);
        logic [16:0] sum;
        sum = {1'b0, cnt} + {15'd0, inc};
        return sum[16] ? 16'hFFFF : sum[15:0];
    endfunction

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_DATA} rstate_t;

    logic [63:0] mem [DEPTH];
    logic        bp_gate;

    logic unused_sig;
    assign unused_sig = ^{s_axi.awprot, s_axi.awcache, s_axi.arprot, s_axi.arcache};

`ifdef AXI_HP_MEM_BACKPRESSURE_EN
    logic [7:0] lfsr;
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) lfsr <= 8'hA5;
        else              lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
    assign bp_gate = lfsr[0];
`else
    assign bp_gate = 1'b1;
`endif

    // ---------------- write channel ----------------
    wstate_t                   wstate, wstate_nxt;
    logic [MEM_ADDR_WIDTH-1:0] waddr;
    logic [3:0]                wlen, wbeat;
    logic                      wincr;
    logic [1:0]                werr_addr, bresp_q;
    logic                      aw_hs, w_hs, b_hs, w_final;

    assign aw_hs   = s_axi.awvalid & s_axi.awready;
    assign w_hs    = s_axi.wvalid & s_axi.wready;
    assign b_hs    = s_axi.bvalid & s_axi.bready;
    assign w_final = (wbeat == wlen);

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) wstate <= W_IDLE;
        else              wstate <= wstate_nxt;
    end

    always_comb begin
        wstate_nxt = wstate;
        case (wstate)
            W_IDLE:  if (aw_hs) wstate_nxt = W_DATA;
            W_DATA:  if (w_hs && w_final) wstate_nxt = W_RESP;
            W_RESP:  if (b_hs) wstate_nxt = W_IDLE;
            default: wstate_nxt = W_IDLE;
        endcase
    end

    always_comb begin
        s_axi.awready = (wstate == W_IDLE);
        s_axi.wready  = (wstate == W_DATA) && bp_gate;
        s_axi.bvalid  = (wstate == W_RESP);
        s_axi.bresp   = bresp_q;
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            wbeat     <= 4'd0;
            werr_addr <= RESP_OKAY;
            bresp_q   <= RESP_OKAY;
        end else if (aw_hs) begin
            wbeat     <= 4'd0;
            werr_addr <= addr_check(s_axi.awaddr, s_axi.awlen, s_axi.awsize, s_axi.awburst);
            bresp_q   <= addr_check(s_axi.awaddr, s_axi.awlen, s_axi.awsize, s_axi.awburst);
        end else if (w_hs) begin
            wbeat <= wbeat + 4'd1;
            // A misplaced wlast downgrades the response but never masks a decode error.
            if ((s_axi.wlast != w_final) && (bresp_q != RESP_DECERR)) bresp_q <= RESP_SLVERR;
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (aw_hs) begin
            waddr <= word_index(s_axi.awaddr);
            wlen  <= s_axi.awlen;
            wincr <= (s_axi.awburst == BURST_INCR);
        end else if (w_hs && wincr) begin
            waddr <= waddr + 1'b1;
        end
    end

    // Gated only on the address-time check so beats ahead of a wlast error still land.
    always_ff @(posedge axi_aclk) begin
        if (w_hs && werr_addr == RESP_OKAY) begin
            for (int i = 0; i < 8; i++) begin
                if (s_axi.wstrb[i]) mem[waddr][8*i +: 8] <= s_axi.wdata[8*i +: 8];
            end
        end
    end

    // ---------------- read channel ----------------
    rstate_t                   rstate, rstate_nxt;
    logic [MEM_ADDR_WIDTH-1:0] raddr;
    logic [3:0]                rlen, rbeat;
    logic                      rincr;
    logic [1:0]                rerr, rresp_q;
    logic [63:0]               rdata_q;
    logic                      rlast_q;
    logic                      ar_hs, r_hs, r_final, fetch;

    assign ar_hs   = s_axi.arvalid & s_axi.arready;
    assign r_hs    = s_axi.rvalid & s_axi.rready;
    assign r_final = (rbeat == rlen);
    assign fetch   = (rstate == R_FETCH) && bp_gate;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) rstate <= R_IDLE;
        else              rstate <= rstate_nxt;
    end

    always_comb begin
        rstate_nxt = rstate;
        case (rstate)
            R_IDLE:  if (ar_hs) rstate_nxt = R_FETCH;
            R_FETCH: if (bp_gate) rstate_nxt = R_DATA;
            R_DATA:  if (r_hs) rstate_nxt = r_final ? R_IDLE : R_FETCH;
            default: rstate_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        s_axi.arready = (rstate == R_IDLE);
        s_axi.rvalid  = (rstate == R_DATA);
        s_axi.rdata   = rdata_q;
        s_axi.rresp   = rresp_q;
        s_axi.rlast   = rlast_q;
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            rbeat   <= 4'd0;
            rerr    <= RESP_OKAY;
            rdata_q <= 64'd0;
            rresp_q <= RESP_OKAY;
            rlast_q <= 1'b0;
        end else begin
            if (ar_hs) begin
                rbeat <= 4'd0;
                rerr  <= addr_check(s_axi.araddr, s_axi.arlen, s_axi.arsize, s_axi.arburst);
            end
            // Read-first: a same-cycle write to raddr is not visible until the next fetch.
            if (fetch) begin
                rdata_q <= (rerr != RESP_OKAY) ? 64'd0 : mem[raddr];
                rresp_q <= rerr;
                rlast_q <= r_final;
            end
            if (r_hs) begin
                rbeat <= rbeat + 4'd1;
                if (r_final) rlast_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge axi_aclk) begin
        if (ar_hs) begin
            raddr <= word_index(s_axi.araddr);
            rlen  <= s_axi.arlen;
            rincr <= (s_axi.arburst == BURST_INCR);
        end else if (r_hs && rincr) begin
            raddr <= raddr + 1'b1;
        end
    end

    // ---------------- error counter ----------------
    logic       b_err, r_err;
    logic [1:0] err_inc;

    assign b_err   = b_hs && (bresp_q != RESP_OKAY);
    assign r_err   = r_hs && rlast_q && (rresp_q != RESP_OKAY);
    assign err_inc = {1'b0, b_err} + {1'b0, r_err};

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) err_count <= 16'd0;
        else              err_count <= sat_add(err_count, err_inc);
    end
endmodule

// File: tb/tb_axi_hp_mem_responder.sv
// Randomised self-checking bench for axi_hp_mem_responder against a word-array reference model.
module tb_axi_hp_mem_responder;
    localparam int          AW    = 10;
    localparam int          DEPTH = 1 << AW;
    localparam logic [31:0] BASE  = 32'h4000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [15:0] err_count;

    always #5 clk = ~clk;

    axi_hp_mem_responder_if bus();

    axi_hp_mem_responder #(.MEM_ADDR_WIDTH(AW), .BASE_ADDR(BASE)) dut (
        .axi_aclk   (clk),
        .axi_aresetn(rst_n),
        .s_axi      (bus),
        .err_count  (err_count)
    );

    int checks = 0;
    int failures = 0;
    int exp_err = 0;

    logic [63:0] mem_m [DEPTH];
    logic [63:0] wd [16];
    logic [7:0]  ws [16];
    logic        wl [16];
    logic [63:0] rd [16];
    logic [1:0]  rr [16];
    logic        rl [16];
    logic [63:0] er_d [16];
    logic [1:0]  er_r;
    logic        er_l [16];
    int          r_lat;
    bit          r_hold_ok;

    // ---------------- reference model ----------------
    function automatic logic [1:0] model_resp(input logic [31:0] a, input int len, input int size, input int burst);
        longint unsigned start, last, win_end;
        start   = {32'd0, a};
        last    = start + 8 * len;
        win_end = {32'd0, BASE} + 8 * DEPTH - 1;
        if (a < BASE) return 2'b11;
        if (burst == 1 && last > win_end) return 2'b11;
        if (size != 3 || burst >= 2) return 2'b10;
        return 2'b00;
    endfunction

    function automatic int model_idx(input logic [31:0] a, input int beat, input int burst);
        int w;
        w = int'((a - BASE) >> 3);
        return (w + ((burst == 1) ? beat : 0)) % DEPTH;
    endfunction

    task automatic model_write(input logic [31:0] a, input int len, input int size, input int burst,
                               output logic [1:0] resp);
        logic [1:0] addr_resp;
        int idx;
        addr_resp = model_resp(a, len, size, burst);
        resp = addr_resp;
        for (int i = 0; i <= len; i++)
            if (wl[i] != (i == len) && resp != 2'b11) resp = 2'b10;
        if (addr_resp == 2'b00) begin
            for (int i = 0; i <= len; i++) begin
                idx = model_idx(a, i, burst);
                for (int b = 0; b < 8; b++)
                    if (ws[i][b]) mem_m[idx][8*b +: 8] = wd[i][8*b +: 8];
            end
        end
        if (resp != 2'b00) exp_err++;
    endtask

    task automatic model_read(input logic [31:0] a, input int len, input int size, input int burst);
        er_r = model_resp(a, len, size, burst);
        for (int i = 0; i <= len; i++) begin
            er_d[i] = (er_r != 2'b00) ? 64'd0 : mem_m[model_idx(a, i, burst)];
            er_l[i] = (i == len);
        end
        if (er_r != 2'b00) exp_err++;
    endtask

    // ---------------- bus drivers ----------------
    task automatic do_write(input logic [31:0] a, input int len, input int size, input int burst,
                            input bit gaps, output logic [1:0] resp, output logic b_prompt);
        int t;
        resp = 2'b01;
        b_prompt = 1'b0;
        bus.awaddr = a; bus.awlen = 4'(len); bus.awsize = 3'(size); bus.awburst = 2'(burst);
        bus.awvalid = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.awready && t < 100);
        if (!bus.awready) begin
            checks++; failures++; $display("FAIL aw_handshake timeout got awready=0 want 1");
            bus.awvalid = 1'b0; return;
        end
        @(posedge clk); #1 bus.awvalid = 1'b0;
        for (int i = 0; i <= len; i++) begin
            if (gaps) repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            bus.wdata = wd[i]; bus.wstrb = ws[i]; bus.wlast = wl[i]; bus.wvalid = 1'b1;
            t = 0;
            do begin @(negedge clk); t++; end while (!bus.wready && t < 100);
            if (!bus.wready) begin
                checks++; failures++; $display("FAIL w_handshake timeout beat=%0d got wready=0 want 1", i);
                bus.wvalid = 1'b0; return;
            end
            @(posedge clk); #1 bus.wvalid = 1'b0; bus.wlast = 1'b0;
        end
        @(negedge clk);
        b_prompt = bus.bvalid;
        bus.bready = 1'b1;
        t = 0;
        while (!bus.bvalid && t < 100) begin @(negedge clk); t++; end
        if (!bus.bvalid) begin
            checks++; failures++; $display("FAIL b_handshake timeout got bvalid=0 want 1");
            bus.bready = 1'b0; return;
        end
        resp = bus.bresp;
        @(posedge clk); #1 bus.bready = 1'b0;
    endtask

    // mode 0: rready always high, 1: toggles 1,0,1,0 per valid cycle, 2: random
    task automatic do_read(input logic [31:0] a, input int len, input int size, input int burst, input int mode);
        int t, beat;
        bit first, toggle, held, go;
        logic [63:0] hd;
        logic [1:0]  hr;
        logic        hl;
        r_lat = 0; r_hold_ok = 1'b1;
        for (int i = 0; i < 16; i++) begin rd[i] = 64'hDEAD; rr[i] = 2'b01; rl[i] = 1'bx; end
        bus.araddr = a; bus.arlen = 4'(len); bus.arsize = 3'(size); bus.arburst = 2'(burst);
        bus.arvalid = 1'b1;
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.arready && t < 100);
        if (!bus.arready) begin
            checks++; failures++; $display("FAIL ar_handshake timeout got arready=0 want 1");
            bus.arvalid = 1'b0; return;
        end
        @(posedge clk); #1 bus.arvalid = 1'b0;
        first = 1'b1; toggle = 1'b1; held = 1'b0; beat = 0; t = 0;
        hd = '0; hr = '0; hl = 1'b0;
        while (beat <= len && t < 400) begin
            @(negedge clk); t++;
            if (first) r_lat++;
            if (bus.rvalid) begin
                first = 1'b0;
                if (held && (bus.rdata !== hd || bus.rresp !== hr || bus.rlast !== hl)) r_hold_ok = 1'b0;
                case (mode)
                    0:       go = 1'b1;
                    1:       begin go = toggle; toggle = !toggle; end
                    default: go = 1'($urandom_range(0, 1));
                endcase
                bus.rready = go;
                if (go) begin
                    rd[beat] = bus.rdata; rr[beat] = bus.rresp; rl[beat] = bus.rlast;
                    beat++; held = 1'b0;
                end else begin
                    held = 1'b1; hd = bus.rdata; hr = bus.rresp; hl = bus.rlast;
                end
            end else begin
                bus.rready = 1'b0;
            end
        end
        if (beat <= len) begin
            checks++; failures++; $display("FAIL r_beats timeout got=%0d want=%0d", beat, len + 1);
        end
        @(posedge clk); #1 bus.rready = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset;
        bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0; bus.awburst = '0; bus.awprot = '0;
        bus.awcache = '0; bus.awvalid = 1'b0; bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0;
        bus.wvalid = 1'b0; bus.bready = 1'b0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0;
        bus.arburst = '0; bus.arprot = '0; bus.arcache = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (bus.awready !== 1'b1) begin failures++; $display("FAIL reset_awready got=%b want=1", bus.awready); end
        checks++; if (bus.arready !== 1'b1) begin failures++; $display("FAIL reset_arready got=%b want=1", bus.arready); end
        checks++; if (bus.wready !== 1'b0) begin failures++; $display("FAIL reset_wready got=%b want=0", bus.wready); end
        checks++; if (bus.bvalid !== 1'b0) begin failures++; $display("FAIL reset_bvalid got=%b want=0", bus.bvalid); end
        checks++; if (bus.bresp !== 2'b00) begin failures++; $display("FAIL reset_bresp got=%0d want=0", bus.bresp); end
        checks++; if (bus.rvalid !== 1'b0) begin failures++; $display("FAIL reset_rvalid got=%b want=0", bus.rvalid); end
        checks++; if (bus.rlast !== 1'b0) begin failures++; $display("FAIL reset_rlast got=%b want=0", bus.rlast); end
        checks++; if (bus.rresp !== 2'b00) begin failures++; $display("FAIL reset_rresp got=%0d want=0", bus.rresp); end
        checks++; if (bus.rdata !== 64'd0) begin failures++; $display("FAIL reset_rdata got=%h want=0", bus.rdata); end
        checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL reset_err_count got=%0d want=0", err_count); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_zero_fill;
        logic [1:0] resp, exp;
        logic       bp;
        for (int b = 0; b < 4; b++) begin
            for (int i = 0; i < 16; i++) begin wd[i] = '0; ws[i] = 8'hFF; wl[i] = (i == 15); end
            model_write(BASE + 32'(b * 128), 15, 3, 1, exp);
            do_write(BASE + 32'(b * 128), 15, 3, 1, 1'b0, resp, bp);
            checks++;
            if (resp !== exp) begin failures++; $display("FAIL zero_fill_bresp blk=%0d got=%0d want=%0d", b, resp, exp); end
        end
    endtask

    task automatic test_incr_write;
        logic [1:0] resp, exp;
        logic       bp;
        logic [7:0] v;
        for (int i = 0; i < 4; i++) begin
            v = 8'(17 * (i + 1));
            wd[i] = {8{v}}; ws[i] = 8'hFF; wl[i] = (i == 3);
        end
        model_write(BASE + 32'h40, 3, 3, 1, exp);
        do_write(BASE + 32'h40, 3, 3, 1, 1'b0, resp, bp);
        checks++; if (resp !== exp) begin failures++; $display("FAIL incr_bresp got=%0d want=%0d", resp, exp); end
        checks++; if (bp !== 1'b1) begin failures++; $display("FAIL incr_bvalid_timing got=%b want=1", bp); end
        checks++; if (err_count !== 16'(exp_err)) begin failures++; $display("FAIL incr_err_count got=%0d want=%0d", err_count, exp_err); end
    endtask

    task automatic test_partial_strobe;
        logic [1:0] resp, exp;
        logic       bp;
        wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'h0F; wl[0] = 1'b1;
        model_write(BASE, 0, 3, 1, exp);
        do_write(BASE, 0, 3, 1, 1'b0, resp, bp);
        checks++; if (resp !== exp) begin failures++; $display("FAIL strobe_bresp got=%0d want=%0d", resp, exp); end
        model_read(BASE, 0, 3, 1);
        do_read(BASE, 0, 3, 1, 0);
        checks++; if (rd[0] !== 64'h0000_0000_FFFF_FFFF) begin failures++; $display("FAIL strobe_rdata got=%h want=00000000ffffffff", rd[0]); end
        checks++; if (rl[0] !== 1'b1) begin failures++; $display("FAIL strobe_rlast got=%b want=1", rl[0]); end
`ifndef AXI_HP_MEM_BACKPRESSURE_EN
        checks++; if (r_lat != 2) begin failures++; $display("FAIL strobe_latency got=%0d want=2", r_lat); end
`else
        checks++; if (r_lat < 2) begin failures++; $display("FAIL strobe_latency got=%0d want>=2", r_lat); end
`endif
    endtask

    task automatic test_read_toggle;
        model_read(BASE + 32'h40, 3, 3, 1);
        do_read(BASE + 32'h40, 3, 3, 1, 1);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd[i] !== er_d[i] || rr[i] !== er_r || rl[i] !== er_l[i]) begin
                failures++;
                $display("FAIL toggle_beat%0d got data=%h resp=%0d last=%b want data=%h resp=%0d last=%b",
                         i, rd[i], rr[i], rl[i], er_d[i], er_r, er_l[i]);
            end
        end
        checks++; if (r_hold_ok !== 1'b1) begin failures++; $display("FAIL toggle_hold got=changed want=stable"); end
    endtask

    task automatic test_out_of_range;
        logic [1:0] resp, exp;
        logic       bp;
        for (int i = 0; i < 8; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; wl[i] = (i == 3); end
        model_write(BASE + 32'd8160, 3, 3, 1, exp);
        do_write(BASE + 32'd8160, 3, 3, 1, 1'b0, resp, bp);
        checks++; if (resp !== exp) begin failures++; $display("FAIL oor_prefill_bresp got=%0d want=%0d", resp, exp); end
        for (int i = 0; i < 8; i++) begin wd[i] = {$urandom, $urandom}; wl[i] = (i == 7); end
        model_write(BASE + 32'd8160, 7, 3, 1, exp);
        do_write(BASE + 32'd8160, 7, 3, 1, 1'b0, resp, bp);
        checks++; if (resp !== 2'b11 || exp !== 2'b11) begin failures++; $display("FAIL oor_decerr got=%0d want=3", resp); end
        checks++; if (err_count !== 16'(exp_err)) begin failures++; $display("FAIL oor_err_count1 got=%0d want=%0d", err_count, exp_err); end
        model_read(BASE + 32'd8160, 3, 3, 1);
        do_read(BASE + 32'd8160, 3, 3, 1, 2);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd[i] !== er_d[i] || rr[i] !== er_r) begin failures++; $display("FAIL oor_unchanged beat=%0d got=%h want=%h", i, rd[i], er_d[i]); end
        end
        model_read(BASE + 32'h40, 3, 2, 1);
        do_read(BASE + 32'h40, 3, 2, 1, 0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd[i] !== 64'd0 || rr[i] !== 2'b10 || rl[i] !== er_l[i]) begin
                failures++; $display("FAIL size_slverr beat=%0d got data=%h resp=%0d want data=0 resp=2", i, rd[i], rr[i]);
            end
        end
        checks++; if (err_count !== 16'(exp_err)) begin failures++; $display("FAIL oor_err_count2 got=%0d want=%0d", err_count, exp_err); end
        wd[0] = '1; ws[0] = 8'hFF; wl[0] = 1'b1;
        model_write(BASE - 32'd8, 0, 3, 1, exp);
        do_write(BASE - 32'd8, 0, 3, 1, 1'b0, resp, bp);
        checks++; if (resp !== exp) begin failures++; $display("FAIL below_base_bresp got=%0d want=%0d", resp, exp); end
        model_read(BASE, 1, 3, 2);
        do_read(BASE, 1, 3, 2, 0);
        checks++; if (rr[0] !== er_r || rr[1] !== er_r || rd[1] !== 64'd0) begin failures++; $display("FAIL wrap_slverr got=%0d want=%0d", rr[1], er_r); end
        checks++; if (err_count !== 16'(exp_err)) begin failures++; $display("FAIL oor_err_count3 got=%0d want=%0d", err_count, exp_err); end
    endtask

    task automatic test_wlast_mismatch;
        logic [1:0] resp, exp;
        logic       bp;
        for (int i = 0; i < 3; i++) begin wd[i] = {$urandom, $urandom}; ws[i] = 8'hFF; wl[i] = 1'b0; end
        model_write(BASE + 32'd160, 1, 3, 1, exp);
        do_write(BASE + 32'd160, 1, 3, 1, 1'b0, resp, bp);
        checks++; if (resp !== 2'b10 || exp !== 2'b10) begin failures++; $display("FAIL wlast_low_bresp got=%0d want=2", resp); end
        checks++; if (bus.awready !== 1'b1) begin failures++; $display("FAIL wlast_idle got awready=%b want=1", bus.awready); end
        for (int i = 0; i < 3; i++) wd[i] = {$urandom, $urandom};
        wl[0] = 1'b1; wl[1] = 1'b0; wl[2] = 1'b1;
        model_write(BASE + 32'd176, 2, 3, 1, exp);
        do_write(BASE + 32'd176, 2, 3, 1, 1'b1, resp, bp);
        checks++; if (resp !== exp) begin failures++; $display("FAIL wlast_early_bresp got=%0d want=%0d", resp, exp); end
        model_read(BASE + 32'd160, 4, 3, 1);
        do_read(BASE + 32'd160, 4, 3, 1, 0);
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (rd[i] !== er_d[i]) begin failures++; $display("FAIL wlast_written beat=%0d got=%h want=%h", i, rd[i], er_d[i]); end
        end
        checks++; if (err_count !== 16'(exp_err)) begin failures++; $display("FAIL wlast_err_count got=%0d want=%0d", err_count, exp_err); end
    endtask

    task automatic test_random;
        logic [1:0]  resp, exp;
        logic        bp;
        logic [31:0] a;
        int len, size, burst, sel;
        for (int n = 0; n < 30; n++) begin
            len = $urandom_range(0, 15);
            a = BASE + 32'($urandom_range(0, 63 - len) * 8) + 32'($urandom_range(0, 7));
            sel = $urandom_range(0, 9);
            burst = (sel < 8) ? 1 : (sel == 8) ? 0 : 2;
            size = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 2) : 3;
            if ($urandom_range(0, 1) == 0) begin
                for (int i = 0; i <= len; i++) begin
                    wd[i] = {$urandom, $urandom}; ws[i] = 8'($urandom);
                    wl[i] = (i == len) ^ ($urandom_range(0, 19) == 0);
                end
                model_write(a, len, size, burst, exp);
                do_write(a, len, size, burst, 1'b1, resp, bp);
                checks++;
                if (resp !== exp) begin failures++; $display("FAIL rand_bresp n=%0d got=%0d want=%0d", n, resp, exp); end
            end else begin
                model_read(a, len, size, burst);
                do_read(a, len, size, burst, 2);
                for (int i = 0; i <= len; i++) begin
                    checks++;
                    if (rd[i] !== er_d[i] || rr[i] !== er_r || rl[i] !== er_l[i]) begin
                        failures++;
                        $display("FAIL rand_read n=%0d beat=%0d got data=%h resp=%0d last=%b want data=%h resp=%0d last=%b",
                                 n, i, rd[i], rr[i], rl[i], er_d[i], er_r, er_l[i]);
                    end
                end
                checks++; if (r_hold_ok !== 1'b1) begin failures++; $display("FAIL rand_hold n=%0d got=changed want=stable", n); end
            end
        end
        checks++; if (err_count !== 16'(exp_err)) begin failures++; $display("FAIL rand_err_count got=%0d want=%0d", err_count, exp_err); end
    endtask

    task automatic test_reset_mid_read;
        int t;
        bus.araddr = BASE + 32'h40; bus.arlen = 4'd3; bus.arsize = 3'd3; bus.arburst = 2'b01;
        bus.arvalid = 1'b1; bus.rready = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.arready && t < 100);
        @(posedge clk); #1 bus.arvalid = 1'b0;
        t = 0;
        do begin @(negedge clk); t++; end while (!bus.rvalid && t < 100);
        checks++; if (bus.rvalid !== 1'b1) begin failures++; $display("FAIL midrst_pre_rvalid got=%b want=1", bus.rvalid); end
        rst_n = 1'b0;
        #1;
        exp_err = 0;
        checks++; if (bus.rvalid !== 1'b0) begin failures++; $display("FAIL midrst_rvalid got=%b want=0", bus.rvalid); end
        checks++; if (bus.arready !== 1'b1) begin failures++; $display("FAIL midrst_arready got=%b want=1", bus.arready); end
        checks++; if (err_count !== 16'd0) begin failures++; $display("FAIL midrst_err_count got=%0d want=0", err_count); end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        model_read(BASE + 32'h40, 3, 3, 1);
        do_read(BASE + 32'h40, 3, 3, 1, 0);
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (rd[i] !== er_d[i] || rr[i] !== er_r || rl[i] !== er_l[i]) begin
                failures++; $display("FAIL midrst_reread beat=%0d got=%h want=%h", i, rd[i], er_d[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_fill();
        test_incr_write();
        test_partial_strobe();
        test_read_toggle();
        test_out_of_range();
        test_wlast_mismatch();
        test_random();
        test_reset_mid_read();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired got=running want=finished");
        $fatal(1, "watchdog");
    end
endmodule
